// File: rtl/dsp_ctrl_pkg.sv
// dsp_ctrl_pkg: shared state, error and sample types for the IDFT frame sequencer
package dsp_ctrl_pkg;
  localparam int IDFT_FRAME_CYCLES = 32;
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_LOCKED = 2'b10;
  typedef enum logic [2:0] {IDLE, ISSUE, FEED, DRAIN, FIN} idft_seq_state_t;
  typedef struct packed {
    logic [15:0] x3;
    logic [15:0] x2;
    logic [15:0] x1;
    logic [15:0] x0;
  } idft_sample_t;
endpackage

// File: rtl/idft_frame_sequencer_if.sv
// idft_frame_sequencer_if: streaming port between the frame sequencer and the IDFT core
interface idft_frame_sequencer_if;
  logic core_next;
  logic [15:0] core_x0;
  logic [15:0] core_x1;
  logic [15:0] core_x2;
  logic [15:0] core_x3;
  logic core_next_out;
  logic [15:0] core_y0;
  logic [15:0] core_y1;
  logic [15:0] core_y2;
  logic [15:0] core_y3;
  modport master(output core_next, core_x0, core_x1, core_x2, core_x3,
                 input core_next_out, core_y0, core_y1, core_y2, core_y3);
  modport slave(input core_next, core_x0, core_x1, core_x2, core_x3,
                output core_next_out, core_y0, core_y1, core_y2, core_y3);
endinterface

// File: rtl/idft_capture_engine.sv
// idft_capture_engine: once armed, stores the FRAME_CYCLES Y samples following next_out into the output buffer
module idft_capture_engine import dsp_ctrl_pkg::*; #(
  parameter int FRAME_CYCLES = IDFT_FRAME_CYCLES,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              disarm,
  input  logic              next_out,
  input  idft_sample_t      y,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [63:0]       rd_data,
  output logic              active,
  output logic              complete
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_CYCLES - 1);
  idft_sample_t mem [FRAME_CYCLES];
  logic armed_q, armed_d, cap_q, cap_d, complete_q, complete_d, go, wrap;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [63:0] rd_data_q;
  // disarm wins over a coincident next_out so a timed-out frame never writes
  always_comb begin
    go = armed_q && next_out && !disarm;
    wrap = cap_q && idx_q == LAST;
    armed_d = arm || (armed_q && !go && !disarm);
    cap_d = !arm && (go || (cap_q && !wrap));
    idx_d = (cap_q && !arm) ? idx_q + ADDR_W'(1) : '0;
    complete_d = !arm && (wrap || complete_q);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      armed_q <= 1'b0;
      cap_q <= 1'b0;
      complete_q <= 1'b0;
      idx_q <= '0;
      rd_data_q <= '0;
    end else begin
      armed_q <= armed_d;
      cap_q <= cap_d;
      complete_q <= complete_d;
      idx_q <= idx_d;
      rd_data_q <= mem[rd_addr];
    end
  always_ff @(posedge clk)
    if (cap_q) mem[idx_q] <= y;
  assign rd_data = rd_data_q;
  assign active = cap_q;
  assign complete = complete_q;
endmodule

// File: rtl/idft_frame_sequencer.sv
// idft_frame_sequencer: feeds one buffered 64-point frame into the IDFT core and gathers its output frame
module idft_frame_sequencer import dsp_ctrl_pkg::*; #(
  parameter int FRAME_CYCLES = IDFT_FRAME_CYCLES,
  parameter int ADDR_W = 5,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_wr_en,
  input  logic [ADDR_W-1:0] in_wr_addr,
  input  logic [63:0]       in_wr_data,
  input  logic [ADDR_W-1:0] out_rd_addr,
  output logic [63:0]       out_rd_data,
  input  logic              start,
  input  logic              key_loaded,
  output logic              busy,
  output logic              done,
  output logic [1:0]        error,
  idft_frame_sequencer_if.master core
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO = TW'(TIMEOUT_CYCLES);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_CYCLES - 1);
  idft_seq_state_t state_q, state_d;
  logic [ADDR_W-1:0] k_q, k_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [1:0] error_q, error_d;
  logic busy_q, done_q, core_next_q, arm, disarm, cap_active, cap_complete;
  idft_sample_t in_mem [FRAME_CYCLES];
  idft_sample_t x;
  always_ff @(posedge clk)
    if (in_wr_en && !busy_q) in_mem[in_wr_addr] <= in_wr_data;
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    error_d = error_q;
    arm = state_q == ISSUE;
    disarm = 1'b0;
    tmo_d = state_q == ISSUE ? '0 : ((state_q == FEED || state_q == DRAIN) && tmo_q != TMO) ? tmo_q + TW'(1) : tmo_q;
    case (state_q)
      IDLE: begin
        state_d = !start ? IDLE : key_loaded ? ISSUE : FIN;
        error_d = !start ? error_q : key_loaded ? ERR_NONE : ERR_LOCKED;
      end
      ISSUE: begin
        state_d = FEED;
        k_d = '0;
      end
      FEED: begin
        k_d = k_q + ADDR_W'(1);
        state_d = k_q == LAST ? DRAIN : FEED;
      end
      DRAIN: begin
        disarm = !cap_complete && !cap_active && tmo_q == TMO;
        state_d = (cap_complete || disarm) ? FIN : DRAIN;
        error_d = cap_complete ? ERR_NONE : disarm ? ERR_TIMEOUT : error_q;
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    x = state_q == FEED ? in_mem[k_q] : '0;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      k_q <= '0;
      tmo_q <= '0;
      error_q <= ERR_NONE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      core_next_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      tmo_q <= tmo_d;
      error_q <= error_d;
      busy_q <= state_d == ISSUE || state_d == FEED || state_d == DRAIN;
      done_q <= state_d == FIN;
      core_next_q <= state_d == ISSUE;
    end
  idft_capture_engine #(.FRAME_CYCLES(FRAME_CYCLES), .ADDR_W(ADDR_W)) u_cap (
    .clk(clk),
    .rst(rst),
    .arm(arm),
    .disarm(disarm),
    .next_out(core.core_next_out),
    .y({core.core_y3, core.core_y2, core.core_y1, core.core_y0}),
    .rd_addr(out_rd_addr),
    .rd_data(out_rd_data),
    .active(cap_active),
    .complete(cap_complete)
  );
  assign busy = busy_q;
  assign done = done_q;
  assign error = error_q;
  assign core.core_next = core_next_q;
  assign core.core_x0 = x.x0;
  assign core.core_x1 = x.x1;
  assign core.core_x2 = x.x2;
  assign core.core_x3 = x.x3;
endmodule

// File: tb/tb_idft_frame_sequencer.sv
// tb_idft_frame_sequencer: scenario tasks with a cycle-level reference of feed, capture and status timing
module tb_idft_frame_sequencer;
  localparam int TMO = 64;
  logic clk = 0, rst = 1;
  logic in_wr_en = 0, start = 0, key_loaded = 0;
  logic [4:0] in_wr_addr = 0, out_rd_addr = 0;
  logic [63:0] in_wr_data = 0, out_rd_data;
  logic busy, done;
  logic [1:0] error;
  int errors = 0, checks = 0;
  logic [63:0] in_model [32];
  logic [63:0] out_model [32];
  logic [63:0] x_log [200];
  logic [63:0] y_log [200];
  logic nx_log [200];
  logic busy_log [200];
  logic done_log [200];
  logic [1:0] err_log [200];
  idft_frame_sequencer_if cif();
  idft_frame_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .in_wr_en(in_wr_en), .in_wr_addr(in_wr_addr), .in_wr_data(in_wr_data),
    .out_rd_addr(out_rd_addr), .out_rd_data(out_rd_data), .start(start), .key_loaded(key_loaded),
    .busy(busy), .done(done), .error(error), .core(cif)
  );
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // cycle 0 is the cycle in which start is presented; the core model drives random Y every cycle
  task automatic run(input int n, input bit key, input int no_at, input int st2_at, input bit wr0, input logic [63:0] wr0_d);
    for (int c = 0; c < n; c++) begin
      start = c == 0 || c == st2_at;
      key_loaded = key;
      in_wr_en = (c == 0 && wr0) || c == st2_at;
      in_wr_addr = c == 0 ? 5'd0 : 5'd20;
      in_wr_data = c == 0 ? wr0_d : ~in_model[20];
      y_log[c] = {$urandom, $urandom};
      {cif.core_y3, cif.core_y2, cif.core_y1, cif.core_y0} = y_log[c];
      cif.core_next_out = c == no_at;
      nx_log[c] = cif.core_next;
      x_log[c] = {cif.core_x3, cif.core_x2, cif.core_x1, cif.core_x0};
      busy_log[c] = busy;
      done_log[c] = done;
      err_log[c] = error;
      tick();
    end
    start = 0;
    in_wr_en = 0;
    cif.core_next_out = 0;
    if (wr0) in_model[0] = wr0_d;
  endtask

  task automatic fill(input bit ramp);
    for (int k = 0; k < 32; k++) begin
      in_wr_en = 1;
      in_wr_addr = 5'(k);
      in_wr_data = ramp ? {16'(k + 3), 16'(k + 2), 16'(k + 1), 16'(k)} : {$urandom, $urandom};
      in_model[k] = in_wr_data;
      tick();
    end
    in_wr_en = 0;
  endtask

  task automatic test_reset();
    #2 rst = 0;
    repeat (2) tick();
    checks++; if (busy !== 0 || done !== 0 || error !== 2'b00) begin errors++; $display("FAIL reset_status busy=%b done=%b error=%b want 0 0 00", busy, done, error); end
    checks++; if (cif.core_next !== 0 || {cif.core_x3, cif.core_x2, cif.core_x1, cif.core_x0} !== 64'h0) begin errors++; $display("FAIL reset_core next=%b x=%h want 0", cif.core_next, {cif.core_x3, cif.core_x2, cif.core_x1, cif.core_x0}); end
    checks++; if (out_rd_data !== 64'h0) begin errors++; $display("FAIL reset_rd got %h want 0", out_rd_data); end
    rst = 1;
    tick();
  endtask

  // keyed frame: next_out at cycle t_no captures Y of cycles t_no+1..t_no+32, done two cycles after the last write
  task automatic test_frame(input string name, input int t_no, input int st2_at, input bit wr0);
    logic [63:0] d0, exp_x;
    int done_c, n;
    d0 = {$urandom, $urandom};
    done_c = t_no + 34;
    n = done_c + 4;
    run(n, 1, t_no, st2_at, wr0, d0);
    for (int j = 0; j < 32; j++) out_model[j] = y_log[t_no + 1 + j];
    for (int c = 0; c < n; c++) begin
      exp_x = (c >= 2 && c <= 33) ? in_model[c - 2] : 64'h0;
      checks++; if (nx_log[c] !== (c == 1)) begin errors++; $display("FAIL %s core_next c=%0d got %b want %b", name, c, nx_log[c], c == 1); end
      checks++; if (x_log[c] !== exp_x) begin errors++; $display("FAIL %s core_x c=%0d got %h want %h", name, c, x_log[c], exp_x); end
      checks++; if (busy_log[c] !== (c >= 1 && c < done_c)) begin errors++; $display("FAIL %s busy c=%0d got %b", name, c, busy_log[c]); end
      checks++; if (done_log[c] !== (c == done_c)) begin errors++; $display("FAIL %s done c=%0d got %b want %b", name, c, done_log[c], c == done_c); end
      if (c >= 1) begin
        checks++; if (err_log[c] !== 2'b00) begin errors++; $display("FAIL %s error c=%0d got %b want 00", name, c, err_log[c]); end
      end
    end
    for (int j = 0; j < 32; j++) begin
      out_rd_addr = 5'(j);
      tick();
      checks++; if (out_rd_data !== out_model[j]) begin errors++; $display("FAIL %s outbuf[%0d] got %h want %h", name, j, out_rd_data, out_model[j]); end
    end
  endtask

  task automatic test_timeout();
    int done_c;
    done_c = TMO + 3;
    run(90, 1, 80, -1, 0, 64'h0);
    for (int c = 1; c < 90; c++) begin
      checks++; if (done_log[c] !== (c == done_c)) begin errors++; $display("FAIL timeout done c=%0d got %b want %b", c, done_log[c], c == done_c); end
      checks++; if (busy_log[c] !== (c < done_c)) begin errors++; $display("FAIL timeout busy c=%0d got %b", c, busy_log[c]); end
      checks++; if (err_log[c] !== (c >= done_c ? 2'b01 : 2'b00)) begin errors++; $display("FAIL timeout error c=%0d got %b", c, err_log[c]); end
    end
    for (int j = 0; j < 32; j++) begin
      out_rd_addr = 5'(j);
      tick();
      checks++; if (out_rd_data !== out_model[j]) begin errors++; $display("FAIL timeout_nowrite outbuf[%0d] got %h want %h", j, out_rd_data, out_model[j]); end
    end
  endtask

  task automatic test_locked();
    run(6, 0, -1, -1, 0, 64'h0);
    for (int c = 0; c < 6; c++) begin
      checks++; if (nx_log[c] !== 0 || busy_log[c] !== 0 || x_log[c] !== 64'h0) begin errors++; $display("FAIL locked core c=%0d next=%b busy=%b x=%h want 0", c, nx_log[c], busy_log[c], x_log[c]); end
      checks++; if (done_log[c] !== (c == 1)) begin errors++; $display("FAIL locked done c=%0d got %b", c, done_log[c]); end
      if (c >= 1) begin
        checks++; if (err_log[c] !== 2'b10) begin errors++; $display("FAIL locked error c=%0d got %b want 10", c, err_log[c]); end
      end
    end
  endtask

  task automatic test_reset_mid_feed();
    start = 1;
    key_loaded = 1;
    tick();
    start = 0;
    repeat (16) tick();
    checks++; if ({cif.core_x3, cif.core_x2, cif.core_x1, cif.core_x0} !== in_model[15]) begin errors++; $display("FAIL midfeed_x got %h want %h", {cif.core_x3, cif.core_x2, cif.core_x1, cif.core_x0}, in_model[15]); end
    #2 rst = 0;
    #1;
    checks++; if ({cif.core_x3, cif.core_x2, cif.core_x1, cif.core_x0} !== 64'h0 || busy !== 0) begin errors++; $display("FAIL async_reset x=%h busy=%b want 0 0", {cif.core_x3, cif.core_x2, cif.core_x1, cif.core_x0}, busy); end
    tick();
    checks++; if (done !== 0 || cif.core_next !== 0) begin errors++; $display("FAIL reset_no_done done=%b next=%b want 0 0", done, cif.core_next); end
    rst = 1;
    tick();
    fill(1);
    test_frame("after_reset", 40, -1, 0);
  endtask

  initial begin
    cif.core_next_out = 0;
    {cif.core_y3, cif.core_y2, cif.core_y1, cif.core_y0} = 64'h0;
    test_reset();
    fill(1);
    test_frame("normal", 40, -1, 0);
    test_timeout();
    test_locked();
    fill(0);
    test_frame("overlap", 12, -1, 0);
    test_reset_mid_feed();
    fill(0);
    test_frame("host_wr", 20, 10, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
